stream_demux: RTL
=================

// Module: stream_demux
// PURPOSE
//  Parametrised 1-to-NCH stream demultiplexer with a valid/ready handshake. Each accepted
//  input beat is steered by in_sel into a one-entry register on the selected output channel.
//  It supersedes the fixed-width combinational 1x2/1x4/1x8 demux trees in the datapath.
//  Sits between a single producer and NCH independent consumers; per-channel backpressure.
// PARAMETERS
//  WIDTH  8   data bits per beat
//  NCH    8   number of output channels (>=2, need not be a power of 2)
//  SELW   3   select width, = $clog2(NCH); set by the parent, checked at elaboration
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous reset, active low
//  in_data    in   WIDTH       input beat
//  in_sel     in   SELW        destination channel, sampled with in_valid
//  in_valid   in   1           producer has a beat
//  in_ready   out  1           beat accepted when in_valid & in_ready
//  out_data   out  NCH*WIDTH   channel k = out_data[k*WIDTH +: WIDTH]
//  out_valid  out  NCH         channel k register holds a beat
//  out_ready  in   NCH         consumer k takes the beat when out_valid[k] & out_ready[k]
//  err_cnt    out  8           count of dropped beats (in_sel >= NCH), saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, err_cnt=0. In-flight beats are discarded.
//    The first accept can occur on the first rising clk edge after rst_n deasserts.
//  - Channel slot k: full flag plus a WIDTH-bit data register. Data is held stable while full.
//  - in_ready: when in_sel<NCH, in_ready = ~full[in_sel] | out_ready[in_sel]
//    (fill-while-drain permitted). When in_sel>=NCH, in_ready=1. Combinational.
//  - Accept to channel k: on that edge data_k<=in_data and full_k<=1.
//    Latency is exactly 1 cycle, input edge to out_valid[k].
//  - Drain only (full_k & out_ready[k] with no new accept to k): full_k<=0 at the edge.
//  - Simultaneous drain and accept on the same k: full_k stays 1 and data_k updates.
//    No bubble; sustained throughput is 1 beat/cycle.
//  - Channels are independent. A stalled channel never blocks beats to other channels.
//  - Out-of-range select: the beat is consumed and dropped, and err_cnt increments.
//    err_cnt saturates at 255 and clears only on reset.
//  - out_ready[k] while out_valid[k]=0 is ignored. in_sel/in_data are ignored when in_valid=0.
// CONFIGURATION
//  STREAM_DEMUX_BCAST_EN defined:
//  - Adds port in_bcast (in, 1).
//  - When in_valid & in_bcast, in_ready = AND over all k of (~full_k | out_ready[k]).
//    On accept, every slot loads in_data. in_sel is ignored and err_cnt is not touched.
//  STREAM_DEMUX_BCAST_EN undefined: the port is absent and only unicast behaviour exists.
// STRUCTURE
//  - Shared include demux_defs.vh holds two constants:
//    - DEMUX_ERR_W = 8 (error counter width)
//    - DEMUX_ERR_MAX = 8'hFF (saturation value)
//  - Sub-module stream_demux_slot holds one channel register: load, drain, full, data.
//    It is instantiated NCH times in a generate loop.
//  - Top level contains only the select decode, the in_ready mux and err_cnt.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, err_cnt=0, no accept occurs.
//  2. Unicast: NCH=8, send 0xA5 with sel=5, out_ready=all 1
//     -> out_valid=8'b0010_0000 one cycle later, channel 5 data=0xA5.
//  3. Backpressure: out_ready[2]=0, send two beats to ch2.
//     -> Second beat sees in_ready=0 and channel 2 holds the first beat.
//     -> A beat to ch3 passes the same cycle.
//  4. Stream: 16 back-to-back beats to ch0 with out_ready[0]=1
//     -> in_ready stays 1, 16 beats out in order, no bubble.
//  5. NCH=5 with sel=6 -> beat accepted and no out_valid.
//     -> Driving 300 such beats gives err_cnt=255.
//  6. With BCAST_EN: in_bcast=1, data 0x3C, out_ready[7]=0 and ch7 full -> in_ready=0.
//     -> After ch7 drains, all 8 channels present 0x3C. Reset mid-stream clears all.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for stream_demux.
// The optional broadcast feature is enabled with STREAM_DEMUX_BCAST_EN.
`include "demux_defs.vh"

package stream_demux_pkg;

    localparam int ERR_W = `DEMUX_ERR_W;
    localparam logic [ERR_W-1:0] ERR_MAX = `DEMUX_ERR_MAX;

    // How the beat currently presented on the input is routed.
    typedef enum logic [1:0] {
        ROUTE_IDLE,
        ROUTE_UNICAST,
        ROUTE_DROP,
        ROUTE_BCAST
    } route_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        return (value == ERR_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Bus bundle between one producer, the demux and NCH consumers.
// in_bcast exists only when STREAM_DEMUX_BCAST_EN is defined.
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = 3
);
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;

`ifdef STREAM_DEMUX_BCAST_EN
    logic                 in_bcast;

    modport master (
        output in_data, in_sel, in_valid, in_bcast, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, in_bcast, out_ready,
        output in_ready, out_data, out_valid
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
`endif

endinterface

// File: rtl/demux_defs.vh
// Constants shared by the stream demux family: the dropped-beat counter's width and its saturation value.
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH

`define DEMUX_ERR_W   8
`define DEMUX_ERR_MAX 8'hFF

`endif

// File: rtl/stream_demux_slot.sv
// One output channel register: a full flag plus a data word held stable while full.
// Loading takes priority over draining so a slot can refill on the edge it empties.
module stream_demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (load) begin
            full_reg <= 1'b1;
            data_reg <= load_data;
        end else if (drain) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign data = data_reg;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NCH valid/ready stream demultiplexer with a one-entry register per channel.
// Define STREAM_DEMUX_BCAST_EN to add in_bcast, which loads every channel at once.
`include "demux_defs.vh"

module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_demux_if.slave    bus,
    output logic [ERR_W-1:0] err_cnt
);

    if (SELW != $clog2(NCH) || NCH < 2) begin : g_param_check
        $error("stream_demux: NCH must be >= 2 and SELW must equal $clog2(NCH)");
    end

    localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

    logic [NCH-1:0]       full;
    logic [NCH-1:0]       slot_ready;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] data_flat;
    logic [2**SELW-1:0]   ready_pad;
    logic                 sel_ok;
    logic                 bcast;
    logic                 ready_int;
    logic                 accept;
    route_e               route;
    logic [ERR_W-1:0]     err_cnt_reg;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast = bus.in_valid & bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = ({1'b0, bus.in_sel} < NCH_W);

    // Padded so that an out-of-range select never indexes past the slot vector.
    always_comb begin
        ready_pad = '0;
        ready_pad[NCH-1:0] = slot_ready;
    end

    always_comb begin
        route = ROUTE_IDLE;
        if (bus.in_valid) begin
            if (bcast)
                route = ROUTE_BCAST;
            else if (sel_ok)
                route = ROUTE_UNICAST;
            else
                route = ROUTE_DROP;
        end
    end

    // Dropped beats are always taken; a broadcast waits for every slot to have room.
    always_comb begin
        ready_int = 1'b1;
        if (bcast)
            ready_int = &slot_ready;
        else if (sel_ok)
            ready_int = ready_pad[bus.in_sel];
    end

    assign accept       = bus.in_valid & ready_int;
    assign bus.in_ready = ready_int;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
        assign slot_ready[gi] = ~full[gi] | bus.out_ready[gi];
        assign load[gi] = accept &
                          ((route == ROUTE_BCAST) ||
                           ((route == ROUTE_UNICAST) && (bus.in_sel == SELW'(gi))));

        stream_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[gi]),
            .load_data (bus.in_data),
            .drain     (bus.out_ready[gi]),
            .full      (full[gi]),
            .data      (data_flat[gi*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_reg <= '0;
        else if (accept && route == ROUTE_DROP)
            err_cnt_reg <= sat_inc(err_cnt_reg);
    end

    assign err_cnt       = err_cnt_reg;
    assign bus.out_valid = full;
    assign bus.out_data  = data_flat;

endmodule
